fetch_pc_unit: RTL and testbench

Instruction-fetch front end that owns the architectural PC register. It consumes redirects from the branch/jump next-PC resolver and issues word fetches to instruction memory over a valid/ready request plus response-valid channel. It presents {instruction, PC} to decode through a single-entry valid/ready output buffer. At most one memory request is outstanding at any time.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_out_buf.sv | 45 ++++
 rtl/fetch_pc_unit.sv | 131 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end (fetch_pc_unit).
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry {instr, pc} output register with valid/ready handshake, load and flush.
module fetch_out_buf
  import fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else begin
      if (i_load) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
      end
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding word fetch at a time.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iRedirect,
  input  logic [XLEN-1:0] iRedirectPc,
  output logic            oImemReqValid,
  output logic [XLEN-1:0] oImemAddr,
  input  logic            iImemReqReady,
  input  logic            iImemRspValid,
  input  logic [XLEN-1:0] iImemRspData,
  output logic            oInstrValid,
  output logic [XLEN-1:0] oInstr,
  output logic [XLEN-1:0] oInstrPc,
  input  logic            iInstrReady
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            oMisalign
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req_valid;

  logic [XLEN-1:0] w_tgt;
  logic            w_tgt_bad;
  logic            w_pc_bad;
  logic            w_owes_rsp;
  logic            w_load;
  logic [XLEN-1:0] w_buf_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_tgt     = iRedirectPc;
  assign w_tgt_bad = (iRedirectPc[1:0] != 2'b00);
  assign w_pc_bad  = (r_pc[1:0] != 2'b00);
`else
  assign w_tgt     = align_pc(iRedirectPc);
  assign w_tgt_bad = 1'b0;
  assign w_pc_bad  = 1'b0;
`endif

  // A request accepted now, or still in flight, owes a response that must be dropped.
  assign w_owes_rsp = ((r_state == REQ) && iImemReqReady) ||
                      (((r_state == WAIT) || (r_state == DRAIN)) && !iImemRspValid);
  assign w_load     = (r_state == WAIT) && iImemRspValid && !iRedirect;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
    end else if (iRedirect) begin
      r_pc <= w_tgt;
      if (w_owes_rsp) begin
        r_state     <= DRAIN;
        r_req_valid <= 1'b0;
      end else if (w_tgt_bad) begin
        r_state     <= FAULT;
        r_req_valid <= 1'b0;
      end else begin
        r_state     <= REQ;
        r_req_valid <= 1'b1;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state     <= REQ;
          r_req_valid <= 1'b1;
        end
        REQ: begin
          if (iImemReqReady) begin
            r_state     <= WAIT;
            r_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (iImemRspValid) begin
            r_pc    <= r_pc + PC_STEP;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (iInstrReady) begin
            r_state     <= REQ;
            r_req_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (iImemRspValid) begin
            r_state     <= w_pc_bad ? FAULT : REQ;
            r_req_valid <= !w_pc_bad;
          end
        end
        default: begin
          r_state     <= FAULT;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  fetch_out_buf u_out_buf (
    .i_clk   (iClk),
    .i_rst_n (iRstN),
    .i_load  (w_load),
    .i_flush (iRedirect),
    .i_instr (iImemRspData),
    .i_pc    (r_pc),
    .i_ready (iInstrReady),
    .o_valid (oInstrValid),
    .o_instr (oInstr),
    .o_pc    (w_buf_pc)
  );

  assign oImemReqValid = r_req_valid;
  assign oImemAddr     = r_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign oMisalign = (r_state == FAULT);
  assign oInstrPc  = (r_state == FAULT) ? r_pc : w_buf_pc;
`else
  assign oInstrPc  = w_buf_pc;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a transaction-level fetch model and a memory responder.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic [31:0] imem_addr;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int lat = 1;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .iClk          (clk),
    .iRstN         (rst_n),
    .iRedirect     (redirect),
    .iRedirectPc   (redirect_pc),
    .oImemReqValid (req_valid),
    .oImemAddr     (imem_addr),
    .iImemReqReady (req_ready),
    .iImemRspValid (rsp_valid),
    .iImemRspData  (rsp_data),
    .oInstrValid   (instr_valid),
    .oInstr        (instr),
    .oInstrPc      (instr_pc),
    .iInstrReady   (instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .oMisalign     (misalign)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: one response, mem_lat cycles after the accepting cycle.
  logic        mem_busy = 1'b0;
  int          mem_t0 = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (mem_busy && ((cyc - mem_t0) == mem_lat)) begin
      rsp_valid = 1'b1;
      rsp_data  = instr_of(mem_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Transaction model: expected next fetch address and queue of {instr, pc} owed to decode.
  logic [31:0] m_pc = RST_PC;
  logic [63:0] m_q[$];
  logic        out_stale = 1'b0;
  logic [31:0] out_addr = '0;
  logic        hold_prev = 1'b0;
  logic        req_hold_prev = 1'b0;
  logic [31:0] hold_instr, hold_pc, req_addr_prev;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] dlv_pc[$];
  int          dlv_cyc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = RST_PC;
      m_q.delete();
      out_stale = 1'b1;
      hold_prev = 1'b0;
      req_hold_prev = 1'b0;
      if (rsp_valid) mem_busy = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("instr_valid held", {31'b0, instr_valid}, 32'd1);
        chk("instr held", instr, hold_instr);
        chk("instr_pc held", instr_pc, hold_pc);
      end
      if (req_hold_prev) begin
        chk("req_valid held", {31'b0, req_valid}, 32'd1);
        chk("imem_addr held", imem_addr, req_addr_prev);
      end
      if (req_valid && req_ready) begin
        chk("fetch addr", imem_addr, m_pc);
        chk("single outstanding", {31'b0, mem_busy}, 32'd0);
        chk("request with buffer full", {31'b0, instr_valid}, 32'd0);
        acc_addr.push_back(imem_addr);
        acc_cyc.push_back(cyc);
      end
      if (instr_valid) begin
        if (m_q.size() == 0) begin
          chk("unexpected instr_valid", {31'b0, instr_valid}, 32'd0);
        end else begin
          chk("instr", instr, m_q[0][63:32]);
          chk("instr_pc", instr_pc, m_q[0][31:0]);
        end
        if (instr_ready) begin
          dlv_pc.push_back(instr_pc);
          dlv_cyc.push_back(cyc);
          if (m_q.size() > 0) void'(m_q.pop_front());
        end
      end
      if (rsp_valid) begin
        if (!out_stale && !redirect) begin
          m_q.push_back({rsp_data, out_addr});
          m_pc = out_addr + 32'd4;
        end
        mem_busy = 1'b0;
      end
      if (redirect) begin
        m_pc = redirect_pc & ~32'h3;
        m_q.delete();
        if (mem_busy) out_stale = 1'b1;
      end
      if (req_valid && req_ready) begin
        mem_busy  = 1'b1;
        mem_t0    = cyc;
        mem_lat   = lat;
        mem_addr  = imem_addr;
        out_addr  = imem_addr;
        out_stale = redirect;
      end
      hold_prev     = instr_valid && !instr_ready && !redirect;
      hold_instr    = instr;
      hold_pc       = instr_pc;
      req_hold_prev = req_valid && !req_ready && !redirect;
      req_addr_prev = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_addr.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (acc_addr.size() < n) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for request %0d", n);
    end
  endtask

  task automatic wait_dlv(input int n, input int budget);
    int k = 0;
    while (dlv_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (dlv_pc.size() < n) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for delivery %0d", n);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for instr_valid");
    end
  endtask

  initial begin
    int na, nd, c;
    repeat (2) tick();
    chk("reset req_valid", {31'b0, req_valid}, 32'd0);
    chk("reset instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset instr", instr, 32'd0);
    chk("reset instr_pc", instr_pc, 32'd0);
    chk("reset imem_addr", imem_addr, RST_PC);
    rst_n = 1'b1;
    base  = cyc;

    // Back-to-back fetch with zero-wait memory and decode.
    wait_acc(3, 20);
    if (acc_addr.size() >= 3) begin
      chk("first addr", acc_addr[0], 32'h100);
      chk("second addr", acc_addr[1], 32'h104);
      chk("third addr", acc_addr[2], 32'h108);
      chk("first req cycle", 32'(acc_cyc[0] - base), 32'd1);
      chk("req spacing 1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("req spacing 2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    wait_dlv(3, 20);
    if (dlv_pc.size() >= 3) begin
      chk("dlv pc 0", dlv_pc[0], 32'h100);
      chk("dlv pc 1", dlv_pc[1], 32'h104);
      chk("dlv pc 2", dlv_pc[2], 32'h108);
      chk("first dlv cycle", 32'(dlv_cyc[0] - base), 32'd3);
    end

    // Decode stall for 5 cycles, then memory stall for 3 cycles.
    wait_valid(20);
    instr_ready = 1'b0;
    na = acc_addr.size();
    repeat (5) tick();
    chk("stall no request", 32'(acc_addr.size()), 32'(na));
    chk("stall instr_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    req_ready   = 1'b0;
    tick();
    chk("request after release", {31'b0, req_valid}, 32'd1);
    repeat (3) tick();
    chk("no accept while not ready", 32'(acc_addr.size()), 32'(na));
    req_ready = 1'b1;
    wait_acc(na + 1, 5);

    // Redirect during WAIT with 3-cycle latency: old response drained.
    lat = 3;
    na  = acc_addr.size();
    wait_acc(na + 1, 20);
    nd = dlv_pc.size();
    na = acc_addr.size();
    c  = cyc;
    do_redirect(32'h200);
    wait_acc(na + 1, 20);
    if (acc_addr.size() > na) begin
      chk("drain redirect addr", acc_addr[na], 32'h200);
      chk("drain redirect latency", 32'(acc_cyc[na] - c), 32'd3);
    end
    wait_dlv(nd + 1, 20);
    if (dlv_pc.size() > nd) chk("first pc after drain", dlv_pc[nd], 32'h200);

    // Redirect coinciding with a response: response dropped.
    lat = 2;
    begin
      int k = 0;
      while (!rsp_valid && k < 20) begin
        tick();
        k++;
      end
    end
    chk("rsp seen for same-cycle redirect", {31'b0, rsp_valid}, 32'd1);
    na = acc_addr.size();
    nd = dlv_pc.size();
    c  = cyc;
    do_redirect(32'h300);
    chk("dropped rsp not shown", {31'b0, instr_valid}, 32'd0);
    wait_acc(na + 1, 10);
    if (acc_addr.size() > na) begin
      chk("same-cycle redirect addr", acc_addr[na], 32'h300);
      chk("same-cycle redirect latency", 32'(acc_cyc[na] - c), 32'd1);
    end
    wait_dlv(nd + 1, 20);
    if (dlv_pc.size() > nd) chk("first pc after 0x300", dlv_pc[nd], 32'h300);

    // Misaligned redirect target.
    lat = 1;
    wait_valid(20);
    na = acc_addr.size();
    c  = cyc;
    do_redirect(32'h202);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign set", {31'b0, misalign}, 32'd1);
    chk("misalign pc", instr_pc, 32'h202);
    repeat (4) tick();
    chk("no request in fault", 32'(acc_addr.size()), 32'(na));
    chk("misalign held", {31'b0, misalign}, 32'd1);
    c = cyc;
    do_redirect(32'h400);
    chk("misalign cleared", {31'b0, misalign}, 32'd0);
    wait_acc(na + 1, 10);
    if (acc_addr.size() > na) chk("addr after fault", acc_addr[na], 32'h400);
`else
    wait_acc(na + 1, 10);
    if (acc_addr.size() > na) begin
      chk("aligned-down addr", acc_addr[na], 32'h200);
      chk("aligned-down latency", 32'(acc_cyc[na] - c), 32'd1);
    end
`endif

    // PC wrap at the top of the address space.
    wait_valid(20);
    na = acc_addr.size();
    do_redirect(32'hFFFF_FFFC);
    wait_acc(na + 2, 20);
    if (acc_addr.size() > na + 1) begin
      chk("wrap addr top", acc_addr[na], 32'hFFFF_FFFC);
      chk("wrap addr zero", acc_addr[na+1], 32'h0000_0000);
    end

    // Reset during WAIT; the late response must be ignored.
    lat = 3;
    na  = acc_addr.size();
    wait_acc(na + 1, 20);
    rst_n = 1'b0;
    #1;
    chk("mid reset req_valid", {31'b0, req_valid}, 32'd0);
    chk("mid reset instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid reset addr", imem_addr, RST_PC);
    req_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("stale rsp ignored", {31'b0, instr_valid}, 32'd0);
    lat = 1;
    na  = acc_addr.size();
    nd  = dlv_pc.size();
    req_ready = 1'b1;
    wait_acc(na + 1, 10);
    if (acc_addr.size() > na) chk("addr after reset", acc_addr[na], 32'h100);
    wait_valid(10);
    chk("instr after reset", instr, instr_of(32'h100));
    wait_dlv(nd + 1, 10);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
